regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RISC-V pipeline: NREAD combinational read ports with write-to-read bypass, one write port, a hardwired-zero register 0, a registered debug read port, and a sequential clear engine that zeroes the whole file on request without a reset. Sits in the decode stage. Replaces the fixed 32×32, two-read, negedge-read register file; the pipeline gets same-cycle write-back visibility without relying on opposite clock edges.

---
 rtl/regfile_pkg.sv | 17 +
 rtl/regfile_clear_fsm.sv | 63 ++++++
 rtl/regfile_mp.sv | 88 ++++++++
 tb/tb_regfile_mp.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file.
// Holds the clear-engine state encoding and the address-width derivation.
package regfile_pkg;

    localparam int NREAD_MIN = 1;
    localparam int NREAD_MAX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int addr_width(input int nregs);
        return (nregs > 1) ? $clog2(nregs) : 1;
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks registers 1..NREGS-1, one per cycle, zeroing each.
// Latency NREGS-1 cycles from clear_req; clear_req while busy is ignored; writes are held off via clear_busy.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = 32,
    parameter int AW    = 5
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          clear_req,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    clr_state_t    state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Register 0 is hardwired, so the walk starts at 1.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        clear_done = 1'b0;
        clr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = AW'(1);
                end
            end
            CLEAR: begin
                clr_en = 1'b1;
                if (cnt == LAST_ADDR) begin
                    clear_done = 1'b1;
                    state_nxt  = IDLE;
                    cnt_nxt    = '0;
                end else begin
                    cnt_nxt = cnt + AW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign clear_busy = (state == CLEAR);
    assign clr_addr   = cnt;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: NREAD combinational read ports with write bypass, one write port, registered debug read.
// Read latency 0, debug latency 1; wr_ready drops while the clear engine runs.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    parameter  int NREAD = 2,
    localparam int AW    = addr_width(NREGS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [NREAD*AW-1:0]   rd_addr,
    output logic [NREAD*XLEN-1:0] rd_data,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic                  wr_ready,
    input  logic                  clear_req,
    output logic                  clear_busy,
    output logic                  clear_done,
    input  logic [AW-1:0]         dbg_addr,
    output logic [XLEN-1:0]       dbg_data
);

    logic [XLEN-1:0] regs [NREGS];
    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    logic            wr_fire;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clock      (clock),
        .reset_n    (reset_n),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .clr_en     (clr_en),
        .clr_addr   (clr_addr)
    );

    assign wr_ready = ~clear_busy;
    // Writes to x0 are accepted at the handshake but never reach storage or bypass.
    assign wr_fire  = wr_en && wr_ready && (wr_addr != '0);

    // Clear and write never coincide: writes are only accepted while the engine is idle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (clr_en) begin
            regs[clr_addr] <= '0;
        end else if (wr_fire) begin
            regs[wr_addr] <= wr_data;
        end
    end

    for (genvar k = 0; k < NREAD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] word;

        assign addr = rd_addr[k*AW +: AW];

        always_comb begin
            word = regs[addr];
            if (addr == '0) begin
                word = '0;
            end else if (wr_fire && (wr_addr == addr)) begin
                word = wr_data;
            end
        end

        assign rd_data[k*XLEN +: XLEN] = word;
    end

    // Pre-update storage value; deliberately no bypass on the debug path.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            dbg_data <= '0;
        end else begin
            dbg_data <= (dbg_addr == '0) ? '0 : regs[dbg_addr];
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp built with four read ports.
// Expectations are queued as stimulus is driven and checked at the following negedge.
module tb_regfile_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NREAD = 4;
    localparam int AW    = 5;

    localparam int K_RD   = 0;
    localparam int K_DBG  = 1;
    localparam int K_BUSY = 2;
    localparam int K_DONE = 3;
    localparam int K_RDY  = 4;

    logic                  clock = 1'b0;
    logic                  reset_n;
    logic [NREAD*AW-1:0]   rd_addr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [XLEN-1:0]       wr_data;
    logic                  wr_ready;
    logic                  clear_req;
    logic                  clear_busy;
    logic                  clear_done;
    logic [AW-1:0]         dbg_addr;
    logic [XLEN-1:0]       dbg_data;

    always #5 clock = ~clock;

    regfile_mp #(
        .XLEN  (XLEN),
        .NREGS (NREGS),
        .NREAD (NREAD)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .clear_req  (clear_req),
        .clear_busy (clear_busy),
        .clear_done (clear_done),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    typedef struct packed {
        logic [2:0]  kind;
        logic [1:0]  port;
        logic [31:0] val;
    } exp_t;

    exp_t        exp_q[$];
    string       tag_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mdl [NREGS];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input int kind, input int port, input logic [31:0] val);
        exp_t e;
        e.kind = 3'(kind);
        e.port = 2'(port);
        e.val  = val;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic sample();
        exp_t        e;
        string       t;
        logic [31:0] got;
        while (exp_q.size() > 0) begin
            e   = exp_q.pop_front();
            t   = tag_q.pop_front();
            got = 32'hxxxx_xxxx;
            if (int'(e.kind) == K_RD)        got = rd_data[int'(e.port)*XLEN +: XLEN];
            else if (int'(e.kind) == K_DBG)  got = dbg_data;
            else if (int'(e.kind) == K_BUSY) got = {31'b0, clear_busy};
            else if (int'(e.kind) == K_DONE) got = {31'b0, clear_done};
            else if (int'(e.kind) == K_RDY)  got = {31'b0, wr_ready};
            check_val($sformatf("%s[p%0d]", t, e.port), got, e.val);
        end
    endtask

    task automatic step();
        @(negedge clock);
        sample();
        @(posedge clock);
        #1;
    endtask

    task automatic set_rd(input int a0, input int a1, input int a2, input int a3);
        rd_addr = {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
    endtask

    // Expected read of every port from the bench model (no bypass).
    task automatic exp_rd(input string tag);
        for (int k = 0; k < NREAD; k++) begin
            logic [AW-1:0] a;
            a = rd_addr[k*AW +: AW];
            push(tag, K_RD, k, (a == '0) ? 32'h0 : mdl[a]);
        end
    endtask

    task automatic write_step(input int a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        step();
        wr_en = 1'b0;
        if (a != 0) mdl[a] = d;
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        reset_n   = 1'b0;
        rd_addr   = '0;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clear_req = 1'b0;
        dbg_addr  = '0;

        #2;
        push("rst_busy", K_BUSY, 0, 0);
        push("rst_done", K_DONE, 0, 0);
        push("rst_dbg", K_DBG, 0, 0);
        sample();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // Reset then read
        set_rd(5, 0, 5, 0);
        dbg_addr = 7;
        exp_rd("rst_rd");
        push("rst_rdy", K_RDY, 0, 1);
        step();

        // Write with same-cycle bypass on all ports
        wr_en   = 1'b1;
        wr_addr = 5;
        wr_data = 32'hDEAD_BEEF;
        set_rd(5, 5, 5, 5);
        for (int k = 0; k < NREAD; k++) push("byp", K_RD, k, 32'hDEAD_BEEF);
        push("rst_dbg7", K_DBG, 0, 0);
        step();
        wr_en  = 1'b0;
        mdl[5] = 32'hDEAD_BEEF;

        set_rd(5, 6, 0, 5);
        dbg_addr = 5;
        exp_rd("wr_hold");
        step();

        // x0 discard
        wr_en   = 1'b1;
        wr_addr = 0;
        wr_data = 32'h1234;
        set_rd(0, 0, 0, 0);
        exp_rd("x0_byp");
        push("dbg5", K_DBG, 0, 32'hDEAD_BEEF);
        dbg_addr = 0;
        step();
        wr_en = 1'b0;
        exp_rd("x0_hold");
        push("dbg_x0", K_DBG, 0, 0);
        step();

        // Fill 1..31 with their index
        for (int i = 1; i < NREGS; i++) begin
            set_rd(i, 0, 0, 0);
            push("fill_byp", K_RD, 0, 32'(i));
            write_step(i, 32'(i));
        end

        // Clear sequence with a rejected mid-clear write
        clear_req = 1'b1;
        set_rd(1, 0, 0, 31);
        push("clr_pre_busy", K_BUSY, 0, 0);
        push("clr_pre_rdy", K_RDY, 0, 1);
        step();
        clear_req = 1'b0;
        for (int i = 1; i < NREGS; i++) begin
            set_rd(i, i - 1, (i == 15 || i == 16) ? 20 : 0, 31);
            if (i == 15) begin
                clear_req = 1'b1;
                wr_en     = 1'b1;
                wr_addr   = 20;
                wr_data   = 32'h5555;
            end
            exp_rd("clr_rd");
            push("clr_busy", K_BUSY, 0, 1);
            push("clr_rdy", K_RDY, 0, 0);
            push("clr_done", K_DONE, 0, (i == NREGS - 1) ? 1 : 0);
            step();
            wr_en     = 1'b0;
            clear_req = 1'b0;
            mdl[i]    = '0;
        end
        push("clr_end_busy", K_BUSY, 0, 0);
        push("clr_end_done", K_DONE, 0, 0);
        push("clr_end_rdy", K_RDY, 0, 1);
        for (int r = 0; r < NREGS / 4; r++) begin
            set_rd(4*r, 4*r + 1, 4*r + 2, 4*r + 3);
            exp_rd("clr_all0");
            step();
        end

        // Clear with simultaneous write to reg 31
        wr_en     = 1'b1;
        wr_addr   = 31;
        wr_data   = 32'hAA;
        clear_req = 1'b1;
        set_rd(31, 0, 0, 0);
        push("cw_byp", K_RD, 0, 32'hAA);
        push("cw_rdy", K_RDY, 0, 1);
        step();
        wr_en     = 1'b0;
        clear_req = 1'b0;
        mdl[31]   = 32'hAA;
        for (int i = 1; i < NREGS; i++) begin
            set_rd(31, i, 0, 0);
            exp_rd("cw_rd");
            push("cw_done", K_DONE, 0, (i == NREGS - 1) ? 1 : 0);
            step();
            mdl[i] = '0;
        end
        set_rd(31, 30, 1, 0);
        exp_rd("cw_after");
        push("cw_busy", K_BUSY, 0, 0);
        step();

        // Reset mid-clear
        write_step(20, 32'h2020);
        write_step(9, 32'h99);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 1; i < 10; i++) begin
            set_rd(20, 9, i, 0);
            exp_rd("rc_rd");
            step();
            mdl[i] = '0;
        end
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < NREGS; i++) mdl[i] = '0;
        set_rd(20, 9, 31, 10);
        exp_rd("rc_rst_rd");
        push("rc_rst_busy", K_BUSY, 0, 0);
        push("rc_rst_done", K_DONE, 0, 0);
        sample();
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        for (int i = 0; i < NREGS; i++) begin
            push("rc_post_busy", K_BUSY, 0, 0);
            push("rc_post_done", K_DONE, 0, 0);
            if (i == 0) push("rc_post_rdy", K_RDY, 0, 1);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
